systolic_tile_ctrl: RTL and testbench

- Sequences one matrix-multiply tile through the activation skew buffer and the N x N output-stationary systolic array.
- Clears the array accumulators, then streams k_len activation columns from an upstream valid/ready source into the skew buffer.
- Feeds zero columns until the last product has propagated, then pulses result_valid/done.
- Sits between the tile DMA/source FIFO and the skew buffer + array; owns their enable and clear strobes.

---
 rtl/systolic_pkg.sv | 22 ++
 rtl/systolic_tile_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_systolic_tile_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic tile controller.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Zero columns needed after the last real column: skew-buffer output
  // register, N-1 skew stages and N-1 PE hops.
  function automatic int drain_cycles(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int count_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/systolic_tile_ctrl.sv
// Tile sequencer for the activation skew buffer and the output-stationary array.
// Optional perf counters (stall_cnt, tile_cycles) under SYSTOLIC_TILE_CTRL_PERF_EN.
module systolic_tile_ctrl
  import systolic_pkg::*;
#(
  parameter int N     = 4,
  parameter int K_MAX = 256,
  parameter int KW    = count_width(K_MAX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          buf_en,
  output logic          zero_fill,
  output logic          array_en,
  output logic          acc_clear,
  output logic          busy,
  output logic          result_valid,
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
  output logic [31:0]   stall_cnt,
  output logic [31:0]   tile_cycles,
`endif
  output logic          done
);

  localparam int            DC     = drain_cycles(N);
  localparam int            DW     = count_width(DC);
  localparam logic [KW-1:0] K_SAT  = KW'(K_MAX);
  localparam logic [DW-1:0] D_LAST = DW'(DC - 1);

  state_e        state_q, state_d;
  logic [KW-1:0] k_len_q, k_len_d;
  logic [KW-1:0] k_cnt_q, k_cnt_d;
  logic [DW-1:0] d_cnt_q, d_cnt_d;
  logic          hs_s;

  assign hs_s = (state_q == STREAM) && in_valid;

  // Next-state and counter logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    k_cnt_d = k_cnt_q;
    d_cnt_d = d_cnt_q;
    if (abort) begin
      state_d = IDLE;
      k_cnt_d = {KW{1'b0}};
      d_cnt_d = {DW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (k_len == {KW{1'b0}}) begin
              state_d = DONE;
            end else begin
              k_len_d = (k_len > K_SAT) ? K_SAT : k_len;
              state_d = CLEAR;
            end
          end else begin
            state_d = IDLE;
          end
        end
        CLEAR: begin
          k_cnt_d = {KW{1'b0}};
          d_cnt_d = {DW{1'b0}};
          state_d = STREAM;
        end
        STREAM: begin
          if (hs_s) begin
            if (k_cnt_q == k_len_q - KW'(1)) begin
              k_cnt_d = {KW{1'b0}};
              state_d = DRAIN;
            end else begin
              k_cnt_d = k_cnt_q + KW'(1);
            end
          end else begin
            k_cnt_d = k_cnt_q;
          end
        end
        DRAIN: begin
          if (d_cnt_q == D_LAST) begin
            d_cnt_d = {DW{1'b0}};
            state_d = DONE;
          end else begin
            d_cnt_d = d_cnt_q + DW'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          k_cnt_d = {KW{1'b0}};
          d_cnt_d = {DW{1'b0}};
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_len_q <= {KW{1'b0}};
      k_cnt_q <= {KW{1'b0}};
      d_cnt_q <= {DW{1'b0}};
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      k_cnt_q <= k_cnt_d;
      d_cnt_q <= d_cnt_d;
    end
  end

  // Output decode: only registered state and in_valid reach the outputs.
  always_comb begin
    in_ready     = 1'b0;
    buf_en       = 1'b0;
    zero_fill    = 1'b0;
    array_en     = 1'b0;
    acc_clear    = 1'b0;
    result_valid = 1'b0;
    done         = 1'b0;
    busy         = (state_q != IDLE);
    case (state_q)
      CLEAR: begin
        acc_clear = 1'b1;
      end
      STREAM: begin
        in_ready = 1'b1;
        buf_en   = hs_s;
        array_en = hs_s;
      end
      DRAIN: begin
        zero_fill = 1'b1;
        buf_en    = 1'b1;
        array_en  = 1'b1;
      end
      DONE: begin
        result_valid = 1'b1;
        done         = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] tile_cycles_q, tile_cycles_d;

  // Perf counters restart on an accepted start and freeze while idle.
  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    tile_cycles_d = tile_cycles_q;
    if (state_q == IDLE) begin
      if (start && !abort) begin
        stall_cnt_d   = 32'd0;
        tile_cycles_d = 32'd0;
      end else begin
        tile_cycles_d = tile_cycles_q;
      end
    end else begin
      tile_cycles_d = tile_cycles_q + 32'd1;
      if ((state_q == STREAM) && !in_valid) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q   <= 32'd0;
      tile_cycles_q <= 32'd0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      tile_cycles_q <= tile_cycles_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign tile_cycles = tile_cycles_q;
`endif

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Scoreboard bench for systolic_tile_ctrl: stimulus queues expected output
// vectors and done events, a negedge monitor pops and compares them.
module tb_systolic_tile_ctrl;

  localparam int KW = 9;

  // Output vector: {in_ready, buf_en, zero_fill, array_en, acc_clear, busy, result_valid, done}
  localparam logic [7:0] V_IDLE = 8'b0000_0000;
  localparam logic [7:0] V_CLR  = 8'b0000_1100;
  localparam logic [7:0] V_STR  = 8'b1101_0100;
  localparam logic [7:0] V_STL  = 8'b1000_0100;
  localparam logic [7:0] V_DRN  = 8'b0111_0100;
  localparam logic [7:0] V_DONE = 8'b0000_0111;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [KW-1:0] k_len;
  logic          abort;
  logic          in_valid;
  logic          in_ready, buf_en, zero_fill, array_en, acc_clear, busy, result_valid, done;
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
  logic [31:0]   stall_cnt, tile_cycles;
`endif
  logic [7:0]    obs_s;

  systolic_tile_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .k_len        (k_len),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .buf_en       (buf_en),
    .zero_fill    (zero_fill),
    .array_en     (array_en),
    .acc_clear    (acc_clear),
    .busy         (busy),
    .result_valid (result_valid),
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
    .stall_cnt    (stall_cnt),
    .tile_cycles  (tile_cycles),
`endif
    .done         (done)
  );

  assign obs_s = {in_ready, buf_en, zero_fill, array_en, acc_clear, busy, result_valid, done};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic [7:0] vec;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_vec(input int c, input logic [7:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.vec  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic expect_range(input int c0, input int c1, input logic [7:0] v, input string nm);
    for (int c = c0; c <= c1; c++) expect_vec(c, v, $sformatf("%s_c%0d", nm, c - c0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare outputs against any vector due this cycle and score done strobes.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      check(e.name, 32'(obs_s), 32'(e.vec));
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done@%0d required=no_done", cyc);
      end else begin
        check("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
        check("result_valid_with_done", 32'(result_valid), 32'd1);
      end
    end
  end

  initial begin : stim
    int b;
    int b2;
    logic pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    reset = 1'b1; start = 1'b0; k_len = '0; abort = 1'b0; in_valid = 1'b0;
    #17;
    check("reset_outs", 32'(obs_s), 32'd0);
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
    check("reset_stall_cnt", stall_cnt, 32'd0);
    check("reset_tile_cycles", tile_cycles, 32'd0);
`endif
    reset = 1'b0;

    // Basic k_len=4 tile with in_valid held high.
    step(); b = cyc; start = 1'b1; k_len = 9'd4; in_valid = 1'b1;
    expect_vec(b, V_IDLE, "s1_idle");
    expect_vec(b + 1, V_CLR, "s1_clear");
    expect_range(b + 2, b + 5, V_STR, "s1_stream");
    expect_range(b + 6, b + 12, V_DRN, "s1_drain");
    expect_vec(b + 13, V_DONE, "s1_done");
    expect_vec(b + 14, V_IDLE, "s1_after");
    done_q.push_back(b + 13);
    step(); start = 1'b0;
    repeat (13) step();
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
    check("s1_stall_cnt", stall_cnt, 32'd0);
    check("s1_tile_cycles", tile_cycles, 32'd13);
`endif

    // k_len=3 with a stalling source.
    step(); b = cyc; start = 1'b1; k_len = 9'd3; in_valid = 1'b0;
    expect_vec(b, V_IDLE, "s2_idle");
    expect_vec(b + 1, V_CLR, "s2_clear");
    for (int i = 0; i < 6; i++) expect_vec(b + 2 + i, pat[i] ? V_STR : V_STL, $sformatf("s2_stream%0d", i));
    expect_range(b + 8, b + 14, V_DRN, "s2_drain");
    expect_vec(b + 15, V_DONE, "s2_done");
    expect_vec(b + 16, V_IDLE, "s2_after");
    done_q.push_back(b + 15);
    step(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(); in_valid = pat[i];
    end
    step(); in_valid = 1'b0;
    repeat (8) step();
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
    check("s2_stall_cnt", stall_cnt, 32'd3);
    check("s2_tile_cycles", tile_cycles, 32'd15);
`endif

    // k_len=0 goes straight to DONE, never clearing or enabling.
    step(); b = cyc; start = 1'b1; k_len = 9'd0; in_valid = 1'b1;
    expect_vec(b, V_IDLE, "s3_idle");
    expect_vec(b + 1, V_DONE, "s3_done");
    expect_vec(b + 2, V_IDLE, "s3_after");
    done_q.push_back(b + 1);
    step(); start = 1'b0;
    step();

    // Abort in the third DRAIN cycle, then a clean k_len=2 tile.
    step(); b = cyc; start = 1'b1; k_len = 9'd4; in_valid = 1'b1;
    expect_vec(b, V_IDLE, "s4_idle");
    expect_vec(b + 1, V_CLR, "s4_clear");
    expect_range(b + 2, b + 5, V_STR, "s4_stream");
    expect_range(b + 6, b + 8, V_DRN, "s4_drain");
    expect_vec(b + 9, V_IDLE, "s4_aborted");
    step(); start = 1'b0;
    repeat (6) step();
    step(); abort = 1'b1;
    step(); abort = 1'b0;
    step(); b2 = cyc; start = 1'b1; k_len = 9'd2;
    expect_vec(b2, V_IDLE, "s4b_idle");
    expect_vec(b2 + 1, V_CLR, "s4b_clear");
    expect_range(b2 + 2, b2 + 3, V_STR, "s4b_stream");
    expect_range(b2 + 4, b2 + 10, V_DRN, "s4b_drain");
    expect_vec(b2 + 11, V_DONE, "s4b_done");
    expect_vec(b2 + 12, V_IDLE, "s4b_after");
    done_q.push_back(b2 + 11);
    step(); start = 1'b0;
    repeat (11) step();

    // Starts while busy are ignored; start right after DONE is accepted.
    step(); b = cyc; start = 1'b1; k_len = 9'd1; in_valid = 1'b1;
    expect_vec(b, V_IDLE, "s5_idle");
    expect_vec(b + 1, V_CLR, "s5_clear");
    expect_vec(b + 2, V_STR, "s5_stream");
    expect_range(b + 3, b + 9, V_DRN, "s5_drain");
    expect_vec(b + 10, V_DONE, "s5_done");
    expect_vec(b + 11, V_IDLE, "s5_idle2");
    expect_vec(b + 12, V_CLR, "s5_clear2");
    expect_range(b + 13, b + 14, V_STR, "s5_stream2");
    expect_range(b + 15, b + 21, V_DRN, "s5_drain2");
    expect_vec(b + 22, V_DONE, "s5_done2");
    expect_vec(b + 23, V_IDLE, "s5_after");
    done_q.push_back(b + 10);
    done_q.push_back(b + 22);
    for (int c = 1; c <= 23; c++) begin
      step();
      start = (c == 1 || c == 3 || c == 7 || c == 10 || c == 11);
      k_len = (c == 11) ? 9'd2 : 9'd0;
    end
    start = 1'b0;

    // Abort during DONE keeps the strobe; abort with start in IDLE drops start.
    step(); b = cyc; start = 1'b1; k_len = 9'd0;
    expect_vec(b, V_IDLE, "s6_idle");
    expect_vec(b + 1, V_DONE, "s6_done_abort");
    expect_vec(b + 2, V_IDLE, "s6_abort_start");
    expect_vec(b + 3, V_IDLE, "s6_dropped");
    done_q.push_back(b + 1);
    step(); start = 1'b0; abort = 1'b1;
    step(); start = 1'b1; abort = 1'b1; k_len = 9'd3;
    step(); start = 1'b0; abort = 1'b0;

    // k_len above K_MAX saturates to 256 columns.
    step(); b = cyc; start = 1'b1; k_len = 9'd300; in_valid = 1'b1;
    expect_vec(b + 257, V_STR, "s7_last_col");
    expect_vec(b + 258, V_DRN, "s7_drain_first");
    expect_vec(b + 264, V_DRN, "s7_drain_last");
    expect_vec(b + 265, V_DONE, "s7_done");
    expect_vec(b + 266, V_IDLE, "s7_after");
    done_q.push_back(b + 265);
    step(); start = 1'b0;
    repeat (265) step();

    // Asynchronous reset mid-STREAM.
    step(); b = cyc; start = 1'b1; k_len = 9'd4; in_valid = 1'b1;
    expect_vec(b, V_IDLE, "s8_idle");
    expect_vec(b + 1, V_CLR, "s8_clear");
    expect_vec(b + 2, V_STR, "s8_stream");
    expect_vec(b + 3, V_IDLE, "s8_in_reset");
    expect_vec(b + 4, V_IDLE, "s8_held");
    expect_vec(b + 5, V_IDLE, "s8_released");
    step(); start = 1'b0;
    step();
    step(); #2 reset = 1'b1;
    #1;
    check("s8_async_outs", 32'(obs_s), 32'd0);
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
    check("s8_stall_cnt", stall_cnt, 32'd0);
    check("s8_tile_cycles", tile_cycles, 32'd0);
`endif
    step(); #3 reset = 1'b0;
    step();
    step();

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
